// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - Op encodings (OP_AND .. OP_MUL) as presented on the Op input.
//   - FSM state type for the alu_mc controller.
package alu_mc_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_EXEC
    } state_e;

endpackage

// File: rtl/alu_mc_addsub.sv
// alu_mc_addsub: combinational WIDTH-bit adder/subtractor shared by ADD and SLT.
//   a, b  : operands
//   sub   : 1 = a - b (b inverted, carry-in 1), 0 = a + b
//   sum   : WIDTH-bit result
//   cout  : carry out of the MSB
//   cmsb  : carry into the MSB (overflow = cmsb ^ cout)
module alu_mc_addsub #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] low;   // low WIDTH-1 bits plus the carry into the MSB
    logic [1:0]       top;

    assign bx   = b ^ {WIDTH{sub}};
    assign low  = {1'b0, a[WIDTH-2:0]} + {1'b0, bx[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub};
    assign cmsb = low[WIDTH-1];
    assign top  = {1'b0, a[WIDTH-1]} + {1'b0, bx[WIDTH-1]} + {1'b0, cmsb};
    assign sum  = {top[0], low[WIDTH-2:0]};
    assign cout = top[1];

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/done handshake and registered outputs.
//   Clock, Reset (async, active-high)
//   Start, A, B, BNegate, Op : request and operands, latched when idle
//   Busy                     : operation in progress, Start ignored
//   Done                     : one-cycle pulse, outputs valid from this cycle
//   Result, Zero, Overflow, CarryOut : registered results, held until next Done
// Logic ops, ADD and SLT finish on the accept edge. Shifts iterate one bit per
// cycle; MUL is an unsigned shift-add over WIDTH cycles.
// Build option: define ALU_MC_MUL_EN to include the multiplier; otherwise
// Op 111 completes at once with Result 0.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BNegate,
    input  logic [2:0]       Op,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut
);

    // Counter must hold both a shift amount and WIDTH (multiply steps).
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_cmsb;
    logic             as_ovf;

    // SLT always subtracts regardless of BNegate.
    alu_mc_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (A),
        .b    (B),
        .sub  ((Op == OP_SLT) | BNegate),
        .sum  (as_sum),
        .cout (as_cout),
        .cmsb (as_cmsb)
    );

    assign as_ovf = as_cmsb ^ as_cout;

`ifdef ALU_MC_MUL_EN
    // acc holds {partial product high half, remaining multiplier bits}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     mul_sum;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_MC_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
`ifdef ALU_MC_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
`ifdef ALU_MC_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d = Op;
                    unique case (Op)
                        OP_AND, OP_OR: begin
                            result_d = (Op == OP_AND) ? (A & B) : (A | B);
                            ovf_d    = 1'b0;
                            carry_d  = 1'b0;
                            done_d   = 1'b1;
                        end
                        OP_ADD: begin
                            result_d = as_sum;
                            ovf_d    = as_ovf;
                            carry_d  = as_cout;
                            done_d   = 1'b1;
                        end
                        OP_SLT: begin
                            // Signed less-than: sign of the difference corrected for overflow.
                            result_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
                            ovf_d    = 1'b0;
                            carry_d  = as_cout;
                            done_d   = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_SRA: begin
                            cnt_d  = CW'(B[SHW-1:0]);
                            work_d = A;
                            if (B[SHW-1:0] == '0) begin
                                result_d = A;
                                ovf_d    = 1'b0;
                                carry_d  = 1'b0;
                                done_d   = 1'b1;
                            end else begin
                                state_d = ST_EXEC;
                            end
                        end
                        default: begin // OP_MUL
`ifdef ALU_MC_MUL_EN
                            cnt_d   = CW'(WIDTH);
                            acc_d   = {{WIDTH{1'b0}}, B};
                            mcand_d = A;
                            state_d = ST_EXEC;
`else
                            result_d = '0;
                            ovf_d    = 1'b0;
                            carry_d  = 1'b0;
                            done_d   = 1'b1;
`endif
                        end
                    endcase
                end
            end

            default: begin // ST_EXEC
                cnt_d = cnt_q - CW'(1);
                case (op_q)
                    OP_SHL:  work_d = {work_q[WIDTH-2:0], 1'b0};
                    OP_SHR:  work_d = {1'b0, work_q[WIDTH-1:1]};
                    default: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                endcase
`ifdef ALU_MC_MUL_EN
                if (op_q == OP_MUL) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
`endif
                // Last step: this edge produces the final value.
                if (cnt_q == CW'(1)) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = work_d;
                    ovf_d    = 1'b0;
                    carry_d  = 1'b0;
`ifdef ALU_MC_MUL_EN
                    if (op_q == OP_MUL) begin
                        result_d = acc_d[WIDTH-1:0];
                        ovf_d    = |acc_d[2*WIDTH-1:WIDTH];
                    end
`endif
                end
            end
        endcase

        if (done_d) begin
            zero_d = (result_d == '0);
        end
    end

    assign Busy     = (state_q == ST_EXEC);
    assign Done     = done_q;
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH = 24), directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W   = 24;
    localparam int SHW = $clog2(W);

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BNegate;
    logic [2:0]   Op;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Overflow;
    logic         CarryOut;

    int errors = 0;
    int checks = 0;

    alu_mc #(
        .WIDTH (W),
        .SHW   (SHW)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .BNegate  (BNegate),
        .Op       (Op),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Zero     (Zero),
        .Overflow (Overflow),
        .CarryOut (CarryOut)
    );

    always #5 Clock = ~Clock;

    // Reference model: plain integer arithmetic on signed/unsigned views.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic bneg,
                                  output logic [W-1:0] res, output logic z,
                                  output logic ov, output logic co, output int lat);
        longint m, ua, ub, sa, sb, t;
        int k;
        m   = longint'(1) << W;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        k   = int'(b[SHW-1:0]);
        res = '0;
        ov  = 1'b0;
        co  = 1'b0;
        lat = 1;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: begin
                t   = bneg ? sa - sb : sa + sb;
                ov  = (t >= m / 2) || (t < -(m / 2));
                t   = bneg ? ua - ub + m : ua + ub;
                co  = (t >= m);
                res = W'(t);
            end
            OP_SLT: begin
                res = (sa < sb) ? W'(1) : W'(0);
                co  = (ua >= ub);
            end
            OP_SHL: begin
                res = (k >= W) ? '0 : W'(ua << k);
                lat = k + 1;
            end
            OP_SHR: begin
                res = (k >= W) ? '0 : W'(ua >> k);
                lat = k + 1;
            end
            OP_SRA: begin
                t   = sa >>> ((k >= W) ? W - 1 : k);
                res = W'(t);
                lat = k + 1;
            end
            default: begin
`ifdef ALU_MC_MUL_EN
                t   = ua * ub;
                res = W'(t);
                ov  = ((t >> W) != 0);
                lat = W + 1;
`endif
            end
        endcase
        z = (res == '0);
    endfunction

    // Issue one request and wait (bounded) for Done; returns what was observed.
    // lat = 0 means Done never arrived. busy_ok = Busy high every cycle before Done
    // and low in the Done cycle.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bneg, input bit no_wait, output int lat,
                         output bit busy_ok, output logic [W-1:0] res, output logic z,
                         output logic ov, output logic co);
        if (!no_wait) @(negedge Clock);
        Start   = 1'b1;
        Op      = op;
        A       = a;
        B       = b;
        BNegate = bneg;
        @(posedge Clock);
        #1;
        Start   = 1'b0;
        A       = W'($urandom);
        B       = W'($urandom);
        Op      = 3'($urandom);
        BNegate = 1'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        res     = 'x;
        z       = 1'bx;
        ov      = 1'bx;
        co      = 1'bx;
        for (int c = 1; c <= 80; c++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                lat = c;
                if (Busy !== 1'b0) busy_ok = 1'b0;
                res = Result;
                z   = Zero;
                ov  = Overflow;
                co  = CarryOut;
                break;
            end
            if (Busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        Reset   = 1'b1;
        Start   = 1'b0;
        A       = '0;
        B       = '0;
        BNegate = 1'b0;
        Op      = OP_AND;
        repeat (2) @(negedge Clock);
        checks++;
        if ({Busy, Done, Zero, Overflow, CarryOut, Result} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got busy=%b done=%b res=%h z=%b ov=%b co=%b, want all 0",
                     Busy, Done, Result, Zero, Overflow, CarryOut);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({Busy, Done, Zero, Overflow, CarryOut, Result} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b res=%h z=%b ov=%b co=%b, want all 0",
                     Busy, Done, Result, Zero, Overflow, CarryOut);
        end
    endtask

    task automatic test_add;
        int lat;
        bit bok;
        logic [W-1:0] r;
        logic z, ov, co;
        do_op(OP_ADD, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 1, bok, r, z, ov, co} !== {1'b1, 1'b1, 24'h800000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ovf: got lat=%0d busy_ok=%b res=%h z=%b ov=%b co=%b, want lat=1 busy_ok=1 res=800000 z=0 ov=1 co=0",
                     lat, bok, r, z, ov, co);
        end
        do_op(OP_ADD, 24'h000005, 24'h000005, 1'b1, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 1, r, z, ov, co} !== {1'b1, 24'h000000, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero: got lat=%0d res=%h z=%b ov=%b co=%b, want lat=1 res=000000 z=1 ov=0 co=1",
                     lat, r, z, ov, co);
        end
    endtask

    task automatic test_slt;
        int lat;
        bit bok;
        logic [W-1:0] r;
        logic z, ov, co;
        do_op(OP_SLT, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 1, r, ov} !== {1'b1, 24'h000001, 1'b0}) begin
            errors++;
            $display("FAIL slt_neg: got lat=%0d res=%h ov=%b, want lat=1 res=000001 ov=0", lat, r, ov);
        end
        do_op(OP_SLT, 24'h000001, 24'hFFFFFF, 1'b1, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 1, r, z, ov} !== {1'b1, 24'h000000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL slt_pos: got lat=%0d res=%h z=%b ov=%b, want lat=1 res=000000 z=1 ov=0",
                     lat, r, z, ov);
        end
    endtask

    // SRA by 4 with a stray Start while busy.
    task automatic test_sra_busy;
        int  lat;
        bit  bok;
        bit  extra;
        @(negedge Clock);
        Start   = 1'b1;
        Op      = OP_SRA;
        A       = 24'h800000;
        B       = 24'd4;
        BNegate = 1'b0;
        @(posedge Clock);
        #1 Start = 1'b0;
        lat = 0;
        bok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clock);
            Start = 1'b0;
            if (Done === 1'b1) begin
                lat = c;
                if (Busy !== 1'b0) bok = 1'b0;
                break;
            end
            if (Busy !== 1'b1) bok = 1'b0;
            if (c == 2) begin
                Start = 1'b1;
                Op    = OP_ADD;
                A     = 24'h000001;
                B     = 24'h000001;
            end
        end
        checks++;
        if ({lat == 5, bok, Result, Zero} !== {1'b1, 1'b1, 24'hF80000, 1'b0}) begin
            errors++;
            $display("FAIL sra_busy: got lat=%0d busy_ok=%b res=%h z=%b, want lat=5 busy_ok=1 res=F80000 z=0",
                     lat, bok, Result, Zero);
        end
        extra = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            if (Done !== 1'b0 || Busy !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0 || Result !== 24'hF80000) begin
            errors++;
            $display("FAIL sra_ignored_start: got extra_activity=%b res=%h, want 0 and F80000",
                     extra, Result);
        end
    endtask

    // Long op, then a new request accepted in its Done cycle.
    task automatic test_back_to_back;
        int lat, elat;
        bit bok;
        logic [W-1:0] r, er;
        logic z, ov, co, ez, eov, eco;
`ifdef ALU_MC_MUL_EN
        do_op(OP_MUL, 24'h001000, 24'h001000, 1'b0, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 25, bok, r, z, ov, co} !== {1'b1, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mul_hi: got lat=%0d busy_ok=%b res=%h z=%b ov=%b co=%b, want lat=25 busy_ok=1 res=000000 z=1 ov=1 co=0",
                     lat, bok, r, z, ov, co);
        end
`else
        model(OP_MUL, 24'h001000, 24'h001000, 1'b0, er, ez, eov, eco, elat);
        do_op(OP_MUL, 24'h001000, 24'h001000, 1'b0, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == elat, bok, r, z, ov, co} !== {1'b1, 1'b1, er, ez, eov, eco}) begin
            errors++;
            $display("FAIL mul_off: got lat=%0d busy_ok=%b res=%h z=%b ov=%b co=%b, want lat=%0d res=%h z=%b ov=%b co=%b",
                     lat, bok, r, z, ov, co, elat, er, ez, eov, eco);
        end
        do_op(OP_SHL, 24'h000003, 24'd6, 1'b0, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 7, bok, r} !== {1'b1, 1'b1, 24'h0000C0}) begin
            errors++;
            $display("FAIL shl6: got lat=%0d busy_ok=%b res=%h, want lat=7 busy_ok=1 res=0000C0",
                     lat, bok, r);
        end
`endif
        // Start driven in the Done cycle of the previous op.
        do_op(OP_ADD, 24'h000100, 24'h000023, 1'b0, 1'b1, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 1, bok, r, co} !== {1'b1, 1'b1, 24'h000123, 1'b0}) begin
            errors++;
            $display("FAIL b2b_add: got lat=%0d busy_ok=%b res=%h co=%b, want lat=1 busy_ok=1 res=000123 co=0",
                     lat, bok, r, co);
        end
    endtask

    task automatic test_reset_midop;
        int lat;
        bit bok;
        bit saw;
        logic [W-1:0] r;
        logic z, ov, co;
        // Leave non-zero outputs behind so clearing is visible.
        do_op(OP_ADD, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, lat, bok, r, z, ov, co);
        @(negedge Clock);
        Start = 1'b1;
`ifdef ALU_MC_MUL_EN
        Op = OP_MUL;
        A  = 24'h001234;
        B  = 24'h005678;
`else
        Op = OP_SRA;
        A  = 24'h812345;
        B  = 24'd20;
`endif
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (9) @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, Zero, Overflow, CarryOut, Result} !== '0) begin
            errors++;
            $display("FAIL reset_midop: got busy=%b done=%b res=%h z=%b ov=%b co=%b, want all 0",
                     Busy, Done, Result, Zero, Overflow, CarryOut);
        end
        @(negedge Clock);
        Reset = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(negedge Clock);
            if (Done !== 1'b0 || Busy !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got activity=%b after abort, want 0", saw);
        end
        do_op(OP_ADD, 24'd2, 24'd3, 1'b0, 1'b0, lat, bok, r, z, ov, co);
        checks++;
        if ({lat == 1, bok, r, z, ov, co} !== {1'b1, 1'b1, 24'd5, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_then_add: got lat=%0d busy_ok=%b res=%h z=%b ov=%b co=%b, want lat=1 res=000005 flags 0",
                     lat, bok, r, z, ov, co);
        end
    endtask

    task automatic test_random;
        int lat, elat;
        bit bok;
        logic [W-1:0] r, er, a, b;
        logic z, ov, co, ez, eov, eco, bn;
        logic [2:0] op;
        logic [W-1:0] edge_vals [5];
        edge_vals[0] = 24'h000000;
        edge_vals[1] = 24'h7FFFFF;
        edge_vals[2] = 24'h800000;
        edge_vals[3] = 24'hFFFFFF;
        edge_vals[4] = 24'h000001;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            bn = 1'($urandom);
            model(op, a, b, bn, er, ez, eov, eco, elat);
            do_op(op, a, b, bn, ($urandom_range(0, 2) == 0), lat, bok, r, z, ov, co);
            checks++;
            if (lat != elat || bok !== 1'b1) begin
                errors++;
                $display("FAIL rand_timing[%0d]: op=%0d a=%h b=%h got lat=%0d busy_ok=%b, want lat=%0d busy_ok=1",
                         i, op, a, b, lat, bok, elat);
            end
            checks++;
            if ({r, z, ov, co} !== {er, ez, eov, eco}) begin
                errors++;
                $display("FAIL rand_value[%0d]: op=%0d a=%h b=%h bneg=%b got res=%h z=%b ov=%b co=%b, want res=%h z=%b ov=%b co=%b",
                         i, op, a, b, bn, r, z, ov, co, er, ez, eov, eco);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_slt();
        test_sra_busy();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
